// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared constants, FSM encoding and width helper for the vertical scaler controller
package scaler_pkg;

  localparam int LINE_STEP_DEF  = 4096;
  localparam int LINE_STEP_LOG2 = $clog2(LINE_STEP_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DIV   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Dividend width: the input height shifted up by the fixed-point fraction bits.
  function automatic int div_width(input int size_width, input int step_log2);
    return size_width + step_log2;
  endfunction

endpackage

// File: rtl/scaler_v_ctrl_if.sv
// rtl/scaler_v_ctrl_if.sv - configuration port bundle between CPU side and the controller
interface scaler_v_ctrl_if #(
  parameter int SIZE_WIDTH = 16
);

  logic [SIZE_WIDTH-1:0] cfg_in_w;
  logic [SIZE_WIDTH-1:0] cfg_in_h;
  logic [SIZE_WIDTH-1:0] cfg_out_h;
  logic                  cfg_wr;
  logic                  cfg_busy;
  logic                  cfg_err;

  modport master (
    output cfg_in_w, cfg_in_h, cfg_out_h, cfg_wr,
    input  cfg_busy, cfg_err
  );

  modport slave (
    input  cfg_in_w, cfg_in_h, cfg_out_h, cfg_wr,
    output cfg_busy, cfg_err
  );

endinterface

// File: rtl/seq_udiv.sv
// rtl/seq_udiv.sv - restoring unsigned divider, one quotient bit per clock
module seq_udiv #(
  parameter int NW = 28,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [DW:0]   remainder
);

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0] q_r;
  logic [DW:0]   r_r;
  logic [CW-1:0] cnt;

  logic [NW-1:0] cur_q;
  logic [DW-1:0] cur_r;
  logic [DW:0]   trial;
  logic          ge;
  logic [NW-1:0] nxt_q;
  logic [DW:0]   nxt_r;

  // One restoring step; the start cycle already performs the first step on the fresh operands.
  always_comb begin
    cur_q = start ? dividend : q_r;
    cur_r = start ? '0 : r_r[DW-1:0];
    trial = {cur_r, cur_q[NW-1]};
    ge    = (trial >= {1'b0, divisor});
    nxt_r = ge ? (trial - {1'b0, divisor}) : trial;
    nxt_q = {cur_q[NW-2:0], ge};
  end

  // Iteration registers; done pulses for one cycle once the last bit is in.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= '0;
      r_r  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q_r  <= nxt_q;
        r_r  <= nxt_r;
        cnt  <= CW'(NW - 1);
        busy <= (NW > 1);
        done <= (NW == 1);
      end else if (busy) begin
        q_r <= nxt_q;
        r_r <= nxt_r;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = q_r;
  assign remainder = r_r;

endmodule

// File: rtl/scaler_v_ctrl.sv
// rtl/scaler_v_ctrl.sv - vertical scaler parameter controller with frame-synchronous apply
module scaler_v_ctrl
  import scaler_pkg::*;
#(
  parameter int LINE_STEP  = LINE_STEP_DEF,
  parameter int SIZE_WIDTH = 16,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  scaler_v_ctrl_if.slave        cfg,
  input  logic                  de_i,
  input  logic                  vs_i,
  output logic                  prm_pending,
  output logic [STEP_WIDTH-1:0] scale_step,
  output logic [SIZE_WIDTH-1:0] line_in_size
);

  localparam int LOG2 = $clog2(LINE_STEP);
  localparam int NW   = div_width(SIZE_WIDTH, LOG2);

  state_t state, state_nxt;

  logic [SIZE_WIDTH-1:0] stg_w, stg_h, stg_oh;
  logic                  err_q, pend_q;
  logic [STEP_WIDTH-1:0] pend_step, step_q;
  logic [SIZE_WIDTH-1:0] pend_size, size_q;

  logic                  div_start, div_busy, div_done;
  logic [NW-1:0]         dividend, quotient;
  logic [SIZE_WIDTH:0]   remainder;
  logic                  unused_div;

  logic cfg_ok, q_ok, frame_start;

  assign cfg_ok      = (stg_w != '0) && (stg_h != '0) && (stg_oh != '0);
  assign q_ok        = (quotient[NW-1:STEP_WIDTH] == '0) && (quotient != '0);
  assign frame_start = de_i & vs_i;
  assign dividend    = {stg_h, {LOG2{1'b0}}};
  assign unused_div  = &{1'b0, div_busy, remainder};

  seq_udiv #(
    .NW (NW),
    .DW (SIZE_WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (dividend),
    .divisor   (stg_oh),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and divider launch; cfg_wr outside IDLE is simply not looked at.
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      ST_IDLE:  if (cfg.cfg_wr) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (cfg_ok) begin
          div_start = 1'b1;
          state_nxt = ST_DIV;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DIV:   if (div_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Staging, error flag, pending set and the live outputs. A frame start applies the
  // pending set before a same-cycle DONE can replace it, so DONE's set waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_w     <= '0;
      stg_h     <= '0;
      stg_oh    <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_step <= '0;
      pend_size <= '0;
      step_q    <= STEP_WIDTH'(LINE_STEP);
      size_q    <= '0;
    end else begin
      if (state == ST_IDLE && cfg.cfg_wr) begin
        stg_w  <= cfg.cfg_in_w;
        stg_h  <= cfg.cfg_in_h;
        stg_oh <= cfg.cfg_out_h;
        err_q  <= 1'b0;
      end
      if (state == ST_CHECK && !cfg_ok) err_q <= 1'b1;
      if (frame_start && pend_q) begin
        step_q <= pend_step;
        size_q <= pend_size;
        pend_q <= 1'b0;
      end
      if (state == ST_DONE) begin
        if (q_ok) begin
          pend_step <= quotient[STEP_WIDTH-1:0];
          pend_size <= stg_w - SIZE_WIDTH'(1);
          pend_q    <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cfg.cfg_busy = (state != ST_IDLE);
  assign cfg.cfg_err  = err_q;
  assign prm_pending  = pend_q;
  assign scale_step   = step_q;
  assign line_in_size = size_q;

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// tb/tb_scaler_v_ctrl.sv - scoreboard bench for scaler_v_ctrl
module tb_scaler_v_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_i = 1'b0;
  logic        vs_i = 1'b0;
  logic        prm_pending;
  logic [15:0] scale_step;
  logic [15:0] line_in_size;

  scaler_v_ctrl_if #(.SIZE_WIDTH(16)) cfg_bus ();

  scaler_v_ctrl #(
    .LINE_STEP  (4096),
    .SIZE_WIDTH (16),
    .STEP_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg          (cfg_bus.slave),
    .de_i         (de_i),
    .vs_i         (vs_i),
    .prm_pending  (prm_pending),
    .scale_step   (scale_step),
    .line_in_size (line_in_size)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the parameters the scaler should be using, and the waiting set.
  int m_step = 4096;
  int m_size = 0;
  int m_pstep = 0;
  int m_psize = 0;
  bit m_pend = 1'b0;
  bit m_err = 1'b0;

  typedef struct {
    int step;
    int size;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_fs();
    exp_t e;
    if (m_pend) begin
      m_step = m_pstep;
      m_size = m_psize;
      m_pend = 1'b0;
    end
    e.step = m_step;
    e.size = m_size;
    sb.push_back(e);
  endtask

  // Monitor: after every frame start the bench drove, compare the live outputs.
  initial begin
    bit   fs;
    exp_t e;
    forever begin
      @(posedge clk);
      fs = de_i & vs_i & ~rst;
      @(negedge clk);
      if (fs) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty got frame start expected none");
        end else begin
          e = sb.pop_front();
          chk("fs_step", scale_step, e.step);
          chk("fs_size", line_in_size, e.size);
        end
      end
    end
  end

  task automatic frame_start();
    @(negedge clk);
    de_i = 1'b1;
    vs_i = 1'b1;
    model_fs();
    @(negedge clk);
    de_i = 1'b0;
    vs_i = 1'b0;
    chk("fs_pending", prm_pending, m_pend);
  endtask

  // One configuration write observed for 33 cycles, with optional frame start,
  // second write or reset injected at a given cycle offset after cfg_wr.
  task automatic run_cfg(input int w, input int h, input int oh,
                         input int fs_k, input int wr2_k, input int rst_k);
    longint q;
    bit     bad, ovf, aborted;
    aborted = 1'b0;
    bad = (w == 0) || (h == 0) || (oh == 0);
    q   = bad ? 0 : (longint'(h) * 4096) / oh;
    ovf = !bad && (q == 0 || q >= 65536);
    @(negedge clk);
    cfg_bus.cfg_in_w  = 16'(w);
    cfg_bus.cfg_in_h  = 16'(h);
    cfg_bus.cfg_out_h = 16'(oh);
    cfg_bus.cfg_wr    = 1'b1;
    m_err = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      cfg_bus.cfg_wr = 1'b0;
      de_i = 1'b0;
      vs_i = 1'b0;
      rst  = 1'b0;
      if (!aborted) begin
        if (k == 2 && bad) m_err = 1'b1;
        if (k == 31 && !bad) begin
          if (ovf) m_err = 1'b1;
          else begin
            m_pend  = 1'b1;
            m_pstep = int'(q);
            m_psize = w - 1;
          end
        end
        if (k == 1) begin
          chk("busy_rise", cfg_bus.cfg_busy, 1);
          chk("err_clear", cfg_bus.cfg_err, 0);
        end
        if (k == 2 && bad) begin
          chk("chk_err", cfg_bus.cfg_err, 1);
          chk("chk_busy", cfg_bus.cfg_busy, 0);
          chk("chk_pending", prm_pending, m_pend);
        end
        if (k == 30 && !bad) begin
          chk("busy_done", cfg_bus.cfg_busy, 1);
          chk("pend_early", prm_pending, m_pend);
        end
        if (k == 31 && !bad) begin
          chk("busy_fall", cfg_bus.cfg_busy, 0);
          chk("done_err", cfg_bus.cfg_err, m_err);
          chk("pend_lat", prm_pending, m_pend);
        end
      end else if (k == rst_k + 1) begin
        chk("rst_step", scale_step, 4096);
        chk("rst_size", line_in_size, 0);
        chk("rst_busy", cfg_bus.cfg_busy, 0);
        chk("rst_pend", prm_pending, 0);
      end
      if (k == rst_k) begin
        rst = 1'b1;
        aborted = 1'b1;
        m_step = 4096;
        m_size = 0;
        m_pend = 1'b0;
        m_err  = 1'b0;
      end
      if (k == wr2_k) begin
        cfg_bus.cfg_in_w  = 16'd640;
        cfg_bus.cfg_in_h  = 16'd480;
        cfg_bus.cfg_out_h = 16'd100;
        cfg_bus.cfg_wr    = 1'b1;
      end
      if (k == fs_k) begin
        de_i = 1'b1;
        vs_i = 1'b1;
        model_fs();
      end
    end
    chk("hold_step", scale_step, m_step);
    chk("hold_size", line_in_size, m_size);
    chk("hold_err", cfg_bus.cfg_err, m_err);
    chk("hold_pend", prm_pending, m_pend);
  endtask

  initial begin
    int mode, w, h, oh, fsk;
    cfg_bus.cfg_in_w  = '0;
    cfg_bus.cfg_in_h  = '0;
    cfg_bus.cfg_out_h = '0;
    cfg_bus.cfg_wr    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_step", scale_step, 4096);
    chk("reset_size", line_in_size, 0);
    chk("reset_busy", cfg_bus.cfg_busy, 0);
    chk("reset_err", cfg_bus.cfg_err, 0);
    chk("reset_pend", prm_pending, 0);
    rst = 1'b0;

    run_cfg(1920, 1080, 720, -1, -1, -1);
    frame_start();
    chk("down_step", scale_step, 6144);
    chk("down_size", line_in_size, 1919);

    run_cfg(1920, 720, 1080, -1, -1, -1);
    chk("up_hold", scale_step, 6144);
    frame_start();
    chk("up_step", scale_step, 2730);

    run_cfg(800, 600, 0, -1, -1, -1);
    run_cfg(1920, 1080, 60, -1, -1, -1);
    chk("ovf_err", cfg_bus.cfg_err, 1);
    chk("ovf_pend", prm_pending, 0);

    run_cfg(1280, 1080, 540, -1, 10, -1);
    frame_start();
    chk("busy_ign_step", scale_step, 8192);
    chk("busy_ign_size", line_in_size, 1279);

    run_cfg(1024, 768, 768, -1, -1, -1);
    run_cfg(640, 480, 320, -1, -1, -1);
    frame_start();
    chk("last_wins_step", scale_step, 6144);
    chk("last_wins_size", line_in_size, 639);

    run_cfg(1920, 1080, 1080, 30, -1, -1);
    chk("coinc_hold", scale_step, 6144);
    frame_start();
    chk("coinc_step", scale_step, 4096);
    chk("coinc_size", line_in_size, 1919);

    run_cfg(1920, 1080, 720, -1, -1, -1);
    run_cfg(1280, 720, 360, -1, -1, 11);
    frame_start();
    chk("rst_fs_step", scale_step, 4096);
    chk("rst_fs_size", line_in_size, 0);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 9);
      w  = $urandom_range(1, 4095);
      h  = $urandom_range(1, 4095);
      oh = $urandom_range(1, 4095);
      if (mode == 0) oh = 0;
      if (mode == 1) begin h = $urandom_range(1024, 4095); oh = $urandom_range(1, 15); end
      if (mode == 2) h = 0;
      if (mode == 3) w = 0;
      if (mode == 4) begin h = $urandom_range(1, 3); oh = $urandom_range(20000, 65535); end
      fsk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : -1;
      run_cfg(w, h, oh, fsk, -1, -1);
      if ($urandom_range(0, 1) == 1) frame_start();
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
